// File: rtl/gesture_servo_sequencer_if.sv
// Gesture/servo bus between the classifier side and the servo sequencer.
// The sequencer takes the slave modport; whoever supplies gestures takes the master.
interface gesture_servo_sequencer_if #(
    parameter int unsigned N_CH = 5
);
    logic [7:0]      gesture;
    logic [N_CH-1:0] pwm_out;
    logic            frame_start;
    logic            busy;
    logic [7:0]      active_gesture;

    modport master (
        output gesture,
        input  pwm_out,
        input  frame_start,
        input  busy,
        input  active_gesture
    );

    modport slave (
        input  gesture,
        output pwm_out,
        output frame_start,
        output busy,
        output active_gesture
    );
endinterface

// File: rtl/gesture_servo_sequencer.sv
// Debounces classifier gestures over PWM frames, slew-limits every finger servo
// toward its table target and drives all servo PWM outputs from one frame counter.
module gesture_servo_sequencer #(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned PERIOD_US     = 20000,
    parameter int unsigned W_MIN_US      = 1000,
    parameter int unsigned W_MAX_US      = 2000,
    parameter int unsigned MID_US        = 1500,
    parameter int unsigned STEP_US       = 10,
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    gesture_servo_sequencer_if.slave bus
);
    localparam int unsigned US_DIV = CLK_HZ / 1_000_000;
    localparam int unsigned US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int unsigned FR_W   = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int unsigned CNT_W  = (STABLE_FRAMES > 1) ? $clog2(STABLE_FRAMES) : 1;

    localparam logic [15:0]        MID_W   = 16'(MID_US);
    localparam logic [15:0]        LOW_W   = 16'(MID_US - 100);
    localparam logic [15:0]        W_MIN_W = 16'(W_MIN_US);
    localparam logic [15:0]        W_MAX_W = 16'(W_MAX_US);
    localparam logic [15:0]        STEP_W  = 16'(STEP_US);
    localparam logic signed [16:0] STEP_S  = 17'(STEP_US);
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(STABLE_FRAMES - 1);

    logic [US_W-1:0]  r_us_cnt;
    logic [FR_W-1:0]  r_frame_us;
    logic             r_frame_start;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_active;
    logic [15:0]      r_cur [N_CH];
    logic [N_CH-1:0]  r_pwm;
    logic             r_busy;

    logic               w_us_tick;
    logic               w_boundary;
    logic [7:0]         w_cand_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [7:0]         w_active_nxt;
    logic [15:0]        w_raw     [N_CH];
    logic [15:0]        w_tgt     [N_CH];
    logic signed [16:0] w_diff    [N_CH];
    logic [15:0]        w_cur_nxt [N_CH];
    logic [N_CH-1:0]    w_pwm_nxt;
    logic               w_busy_nxt;

    assign w_us_tick  = (r_us_cnt == US_W'(US_DIV - 1));
    assign w_boundary = w_us_tick && (r_frame_us == FR_W'(PERIOD_US - 1));

    // Debouncer: a code must be seen on STABLE_FRAMES consecutive boundaries
    always_comb begin
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        if (w_boundary) begin
            if (bus.gesture == r_cand) begin
                w_cnt_nxt = (r_cnt == CNT_TOP) ? r_cnt : r_cnt + CNT_W'(1);
                if (w_cnt_nxt == CNT_TOP) begin
                    w_active_nxt = r_cand;
                end
            end else begin
                w_cand_nxt = bus.gesture;
                w_cnt_nxt  = '0;
                if (STABLE_FRAMES == 1) begin
                    w_active_nxt = bus.gesture;
                end
            end
        end
    end

    // Gesture table, clamped into the legal pulse range
    always_comb begin
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            case (r_active)
                8'h01:   w_raw[ch] = MID_W;
                8'h02:   w_raw[ch] = LOW_W;
                8'h04:   w_raw[ch] = W_MAX_W;
                8'h08:   w_raw[ch] = W_MIN_W;
                8'h10:   w_raw[ch] = (ch == 1) ? W_MIN_W : W_MAX_W;
                default: w_raw[ch] = MID_W;
            endcase
            if (w_raw[ch] < W_MIN_W) begin
                w_tgt[ch] = W_MIN_W;
            end else if (w_raw[ch] > W_MAX_W) begin
                w_tgt[ch] = W_MAX_W;
            end else begin
                w_tgt[ch] = w_raw[ch];
            end
        end
    end

    // Slew limiter, PWM compare and busy flag per channel
    always_comb begin
        w_pwm_nxt  = '0;
        w_busy_nxt = 1'b0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            w_diff[ch] = $signed({1'b0, w_tgt[ch]}) - $signed({1'b0, r_cur[ch]});
            if (w_diff[ch] > STEP_S) begin
                w_cur_nxt[ch] = r_cur[ch] + STEP_W;
            end else if (w_diff[ch] < -STEP_S) begin
                w_cur_nxt[ch] = r_cur[ch] - STEP_W;
            end else begin
                w_cur_nxt[ch] = w_tgt[ch];
            end
            if (r_cur[ch] != w_tgt[ch]) begin
                w_busy_nxt = 1'b1;
            end
            w_pwm_nxt[ch] = (32'(r_frame_us) < 32'(r_cur[ch]));
        end
    end

    // Widths only change on the boundary edge, so no frame sees a partial update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_us_cnt      <= '0;
            r_frame_us    <= '0;
            r_frame_start <= 1'b0;
            r_cand        <= 8'h01;
            r_cnt         <= '0;
            r_active      <= 8'h01;
            r_pwm         <= '0;
            r_busy        <= 1'b0;
            for (int ch = 0; ch < int'(N_CH); ch++) begin
                r_cur[ch] <= MID_W;
            end
        end else begin
            r_us_cnt <= w_us_tick ? '0 : r_us_cnt + US_W'(1);
            if (w_us_tick) begin
                r_frame_us <= (r_frame_us == FR_W'(PERIOD_US - 1)) ? '0 : r_frame_us + FR_W'(1);
            end
            r_frame_start <= w_boundary;
            r_cand        <= w_cand_nxt;
            r_cnt         <= w_cnt_nxt;
            r_active      <= w_active_nxt;
            r_pwm         <= w_pwm_nxt;
            r_busy        <= w_busy_nxt;
            if (w_boundary) begin
                for (int ch = 0; ch < int'(N_CH); ch++) begin
                    r_cur[ch] <= w_cur_nxt[ch];
                end
            end
        end
    end

    assign bus.pwm_out        = r_pwm;
    assign bus.frame_start    = r_frame_start;
    assign bus.busy           = r_busy;
    assign bus.active_gesture = r_active;
endmodule

// File: tb/tb_gesture_servo_sequencer.sv
// Directed, table-driven bench for gesture_servo_sequencer: one 5-channel/3-frame
// instance and one 1-channel/immediate-accept instance, measured frame by frame.
module tb_gesture_servo_sequencer;
    localparam int unsigned CLK_HZ    = 2_000_000;
    localparam int unsigned PERIOD_US = 420;
    localparam int unsigned W_MIN_US  = 200;
    localparam int unsigned W_MAX_US  = 400;
    localparam int unsigned MID_US    = 300;
    localparam int unsigned STEP_US   = 20;
    localparam int          DIV       = 2;
    localparam int          FRAME_CYC = 840;

    typedef struct {
        logic [7:0] g;
        logic [7:0] act;
        int         w0;
        int         w1;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst2;
    logic [7:0] g;
    logic       sel;
    int         nch;
    int         n_chk = 0;
    int         n_err = 0;
    vec_t       vec[$];

    always #5 clk = ~clk;

    gesture_servo_sequencer_if #(.N_CH(5)) bus1 ();
    gesture_servo_sequencer_if #(.N_CH(1)) bus2 ();

    assign bus1.gesture = g;
    assign bus2.gesture = g;

    gesture_servo_sequencer #(
        .N_CH(5), .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .W_MIN_US(W_MIN_US),
        .W_MAX_US(W_MAX_US), .MID_US(MID_US), .STEP_US(STEP_US), .STABLE_FRAMES(3)
    ) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    gesture_servo_sequencer #(
        .N_CH(1), .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .W_MIN_US(W_MIN_US),
        .W_MAX_US(W_MAX_US), .MID_US(MID_US), .STEP_US(STEP_US), .STABLE_FRAMES(1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    logic [4:0] s_pwm;
    logic       s_fs;
    logic       s_busy;
    logic [7:0] s_act;
    assign s_pwm  = sel ? {4'b0, bus2.pwm_out} : bus1.pwm_out;
    assign s_fs   = sel ? bus2.frame_start : bus1.frame_start;
    assign s_busy = sel ? bus2.busy : bus1.busy;
    assign s_act  = sel ? bus2.active_gesture : bus1.active_gesture;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input logic [7:0] gv, input logic [7:0] av, input int w0,
                       input int w1, input logic bv);
        vec_t v;
        v.g = gv; v.act = av; v.w0 = w0; v.w1 = w1; v.busy = bv;
        vec.push_back(v);
    endtask

    // Starts on the negedge just before a frame's first edge, ends on the next frame_start
    task automatic run_frame(input int idx);
        vec_t v;
        int   cnt[5];
        int   fs_early;
        logic b_mid;
        v = vec[idx];
        g = v.g;
        chk($sformatf("f%0d active_gesture", idx), int'(s_act), int'(v.act));
        for (int ch = 0; ch < 5; ch++) cnt[ch] = 0;
        fs_early = 0;
        b_mid    = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            for (int ch = 0; ch < 5; ch++) cnt[ch] += s_pwm[ch] ? 1 : 0;
            if (i == FRAME_CYC / 2) b_mid = s_busy;
            if (i < FRAME_CYC - 1 && s_fs) fs_early++;
        end
        for (int ch = 0; ch < nch; ch++) begin
            chk($sformatf("f%0d width ch%0d", idx, ch), cnt[ch],
                DIV * ((ch == 1) ? v.w1 : v.w0));
        end
        chk($sformatf("f%0d busy", idx), int'(b_mid), int'(v.busy));
        chk($sformatf("f%0d frame_start at boundary", idx), int'(s_fs), 1);
        chk($sformatf("f%0d frame_start early", idx), fs_early, 0);
    endtask

    initial begin
        // fist from reset (0..8)
        add(8'h04, 8'h01, 300, 300, 1'b0);
        add(8'h04, 8'h01, 300, 300, 1'b0);
        add(8'h04, 8'h01, 300, 300, 1'b0);
        add(8'h04, 8'h04, 300, 300, 1'b1);
        add(8'h04, 8'h04, 320, 320, 1'b1);
        add(8'h04, 8'h04, 340, 340, 1'b1);
        add(8'h04, 8'h04, 360, 360, 1'b1);
        add(8'h04, 8'h04, 380, 380, 1'b1);
        add(8'h04, 8'h04, 400, 400, 1'b0);
        // glitch rejection after reset (9..14)
        add(8'h08, 8'h01, 300, 300, 1'b0);
        add(8'h08, 8'h01, 300, 300, 1'b0);
        add(8'h01, 8'h01, 300, 300, 1'b0);
        add(8'h01, 8'h01, 300, 300, 1'b0);
        add(8'h01, 8'h01, 300, 300, 1'b0);
        add(8'h01, 8'h01, 300, 300, 1'b0);
        // point, then unknown code 0x03 mid-slew (15..26)
        add(8'h10, 8'h01, 300, 300, 1'b0);
        add(8'h10, 8'h01, 300, 300, 1'b0);
        add(8'h10, 8'h01, 300, 300, 1'b0);
        add(8'h10, 8'h10, 300, 300, 1'b1);
        add(8'h03, 8'h10, 320, 280, 1'b1);
        add(8'h03, 8'h10, 340, 260, 1'b1);
        add(8'h03, 8'h10, 360, 240, 1'b1);
        add(8'h03, 8'h03, 380, 220, 1'b1);
        add(8'h03, 8'h03, 360, 240, 1'b1);
        add(8'h03, 8'h03, 340, 260, 1'b1);
        add(8'h03, 8'h03, 320, 280, 1'b1);
        add(8'h03, 8'h03, 300, 300, 1'b0);
        // fist again, reset comes in the frame after these (27..30)
        add(8'h04, 8'h03, 300, 300, 1'b0);
        add(8'h04, 8'h03, 300, 300, 1'b0);
        add(8'h04, 8'h03, 300, 300, 1'b0);
        add(8'h04, 8'h04, 300, 300, 1'b1);
        // after mid-slew reset (31..32)
        add(8'h01, 8'h01, 300, 300, 1'b0);
        add(8'h01, 8'h01, 300, 300, 1'b0);
        // single channel, immediate acceptance (33..39)
        add(8'h10, 8'h01, 300, 0, 1'b0);
        add(8'h10, 8'h10, 300, 0, 1'b1);
        add(8'h10, 8'h10, 320, 0, 1'b1);
        add(8'h10, 8'h10, 340, 0, 1'b1);
        add(8'h10, 8'h10, 360, 0, 1'b1);
        add(8'h10, 8'h10, 380, 0, 1'b1);
        add(8'h10, 8'h10, 400, 0, 1'b0);

        rst  = 1'b1;
        rst2 = 1'b1;
        g    = 8'h01;
        sel  = 1'b0;
        nch  = 5;
        repeat (3) @(negedge clk);
        chk("reset pwm_out", int'(s_pwm), 0);
        chk("reset frame_start", int'(s_fs), 0);
        chk("reset busy", int'(s_busy), 0);
        chk("reset active_gesture", int'(s_act), 1);
        rst = 1'b0;
        for (int i = 0; i <= 8; i++) run_frame(i);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 9; i <= 30; i++) run_frame(i);

        // reset asserted between clock edges while every pulse is high
        g = 8'h04;
        chk("slew active_gesture", int'(s_act), 4);
        repeat (100) @(negedge clk);
        chk("pwm before reset", int'(s_pwm), 31);
        chk("busy before reset", int'(s_busy), 1);
        #3 rst = 1'b1;
        #1;
        chk("pwm at async reset", int'(s_pwm), 0);
        chk("active_gesture at async reset", int'(s_act), 1);
        chk("busy at async reset", int'(s_busy), 0);
        chk("frame_start at async reset", int'(s_fs), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 31; i <= 32; i++) run_frame(i);

        sel = 1'b1;
        nch = 1;
        #1;
        chk("n1 reset pwm_out", int'(s_pwm), 0);
        chk("n1 reset active_gesture", int'(s_act), 1);
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 33; i <= 39; i++) run_frame(i);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
